tile_ram_arbiter: RTL and testbench

- Owns the single-port tile RAM that holds the 40x30 playfield (one tile code per 16x16-pixel cell).
- Shares that RAM between two users:
  - the pixel renderer, which gets hard-priority fetches slaved to the 640x480 timing counters hc/vc;
  - the game logic, served through a req/ack port in every cycle the renderer does not need.
- Also emits a once-per-frame tick at the start of vertical blanking, which paces game updates.

---
 rtl/tile_ram_arbiter.sv | 171 +++++++++++++++++
 tb/tb_tile_ram_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_ram_arbiter.sv
// Tile RAM arbiter: renderer fetches take fixed slots tied to hc/vc, game logic uses the
// remaining port cycles through req/ack. Optional macro BLANK_WRITE_ONLY_EN holds game writes until vblank.
module tile_ram_arbiter #(
  parameter int HBP       = 144,
  parameter int HFP       = 784,
  parameter int VBP       = 31,
  parameter int VFP       = 511,
  parameter int CELL_LOG2 = 4,
  parameter int COLS      = 40,
  parameter int ROWS      = 30,
  parameter int AW        = 11,
  parameter int DW        = 4
) (
  input  logic          dclk,
  input  logic          rst_n,
  input  logic [9:0]    hc,
  input  logic [9:0]    vc,
  input  logic          g_req,
  input  logic          g_we,
  input  logic [AW-1:0] g_addr,
  input  logic [DW-1:0] g_wdata,
  output logic          g_ack,
  output logic [DW-1:0] g_rdata,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic [DW-1:0] tile_code,
  output logic          tile_valid,
  output logic          frame_tick
);

  localparam logic [9:0]    H_LAST = 10'd799;
  localparam logic [9:0]    V_LAST = 10'd520;
  localparam logic [9:0]    HBP_W  = 10'(HBP);
  localparam logic [9:0]    HFP_W  = 10'(HFP);
  localparam logic [9:0]    VBP_W  = 10'(VBP);
  localparam logic [9:0]    VFP_W  = 10'(VFP);
  localparam logic [9:0]    HDEC0  = 10'(HBP - 3);
  localparam logic [9:0]    COLS_W = 10'(COLS);
  localparam logic [AW-1:0] CELLS  = AW'(COLS * ROWS);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t        state_q;
  logic          g_ack_q, g_rd_q;
  logic          ram_en_q, ram_we_q;
  logic [AW-1:0] ram_addr_q;
  logic [DW-1:0] ram_wdata_q;
  logic          disp_en_q, disp_rd_q;
  logic [DW-1:0] tile_code_q;
  logic          tile_valid_q, frame_tick_q;

  logic          ram_en_d, ram_we_d;
  logic [AW-1:0] ram_addr_d;
  logic [DW-1:0] ram_wdata_d;
  logic [DW-1:0] tile_code_d;
  logic          tile_valid_d, frame_tick_d;

  logic          pos_ok, vwin, dec, g_ok, accept;
  logic [9:0]    hoff, kx, vrel, h_nxt, v_nxt;
  logic [AW-1:0] row, disp_addr;

  always_comb begin
    pos_ok    = (hc <= H_LAST) && (vc <= V_LAST);
    vwin      = pos_ok && (vc >= VBP_W) && (vc < VFP_W);
    hoff      = hc - HDEC0;
    kx        = hoff >> CELL_LOG2;
    dec       = vwin && (hc >= HDEC0) && (hoff[CELL_LOG2-1:0] == '0) && (kx < COLS_W);
    vrel      = vc - VBP_W;
    row       = AW'(vrel >> CELL_LOG2);
    // row*40 built from two shifts so no multiplier is inferred
    disp_addr = (row << 5) + (row << 3) + AW'(kx);

    // Registered pixel-aligned outputs are computed from the position one clock ahead
    h_nxt        = (hc == H_LAST) ? 10'd0 : hc + 10'd1;
    v_nxt        = (hc == H_LAST) ? ((vc == V_LAST) ? 10'd0 : vc + 10'd1) : vc;
    tile_valid_d = pos_ok && (h_nxt >= HBP_W) && (h_nxt < HFP_W) &&
                   (v_nxt >= VBP_W) && (v_nxt < VFP_W);
    frame_tick_d = pos_ok && (h_nxt == 10'd0) && (v_nxt == VFP_W);
    tile_code_d  = tile_valid_d ? (disp_rd_q ? ram_rdata : tile_code_q) : '0;

    g_ok   = (g_addr < CELLS);
`ifdef BLANK_WRITE_ONLY_EN
    accept = (state_q == IDLE) && g_req && !dec && (!g_we || !vwin);
`else
    accept = (state_q == IDLE) && g_req && !dec;
`endif

    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = '0;
    ram_wdata_d = '0;
    if (dec) begin
      ram_en_d   = 1'b1;
      ram_addr_d = disp_addr;
    end else if (accept) begin
      ram_en_d    = g_ok;
      ram_we_d    = g_we && g_ok;
      ram_addr_d  = g_addr;
      ram_wdata_d = g_wdata;
    end
  end

  always_ff @(posedge dclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      g_ack_q <= 1'b0;
      g_rd_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          g_ack_q <= 1'b0;
          if (accept) begin
            state_q <= ISSUE;
            g_rd_q  <= !g_we && g_ok;
          end
        end
        ISSUE: begin
          state_q <= DONE;
          g_ack_q <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          g_ack_q <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          g_ack_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge dclk or negedge rst_n) begin
    if (!rst_n) begin
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      disp_en_q    <= 1'b0;
      disp_rd_q    <= 1'b0;
      tile_code_q  <= '0;
      tile_valid_q <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      ram_en_q     <= ram_en_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      disp_en_q    <= dec;
      disp_rd_q    <= disp_en_q;
      tile_code_q  <= tile_code_d;
      tile_valid_q <= tile_valid_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign g_ack      = g_ack_q;
  // Read data passes straight from the RAM in the ack cycle
  assign g_rdata    = (g_ack_q && g_rd_q) ? ram_rdata : '0;
  assign ram_en     = ram_en_q;
  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign tile_code  = tile_code_q;
  assign tile_valid = tile_valid_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_tile_ram_arbiter.sv
// Bench for tile_ram_arbiter: behavioural tile RAM, directed scenarios and random game
// traffic, all outputs compared every cycle against an in-bench reference.
`timescale 1ns/1ps
module tb_tile_ram_arbiter;
  localparam int HBP = 144, HFP = 784, VBP = 31, VFP = 511;
  localparam int COLS = 40, ROWS = 30, AW = 11, DW = 4;
  localparam int NCELL = COLS * ROWS;

  logic          dclk = 1'b0;
  logic          rst_n = 1'b0;
  logic [9:0]    hc = '0, vc = '0;
  logic          g_req = 1'b0, g_we = 1'b0;
  logic [AW-1:0] g_addr = '0;
  logic [DW-1:0] g_wdata = '0;
  logic          g_ack, ram_en, ram_we, tile_valid, frame_tick;
  logic [DW-1:0] g_rdata, ram_wdata, ram_rdata, tile_code;
  logic [AW-1:0] ram_addr;

  int errors = 0;
  int checks = 0;

  always #20 dclk = ~dclk;

  tile_ram_arbiter dut (
    .dclk(dclk), .rst_n(rst_n), .hc(hc), .vc(vc),
    .g_req(g_req), .g_we(g_we), .g_addr(g_addr), .g_wdata(g_wdata),
    .g_ack(g_ack), .g_rdata(g_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .tile_code(tile_code), .tile_valid(tile_valid),
    .frame_tick(frame_tick)
  );

  function automatic logic [DW-1:0] init_val(int i);
    if (i == 85) return 4'h9;
    if (i == 1199) return 4'hA;
    return 4'((i * 7 + 3) ^ (i >> 3));
  endfunction

  // Behavioural synchronous single-port tile RAM
  logic [DW-1:0] mem [0:2047];
  logic [DW-1:0] rdata_q = '0;
  bit            mem_init = 1'b0;
  always @(posedge dclk) begin
    if (!mem_init) begin
      for (int i = 0; i < 2048; i++) mem[i] <= init_val(i);
      mem_init <= 1'b1;
    end else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else rdata_q <= mem[ram_addr];
    end
  end
  assign ram_rdata = rdata_q;

  // Reference model state
  logic [DW-1:0] ref_mem [0:2047];
  logic [DW-1:0] fetch_val [0:COLS-1];
  int cyc = 0;
  bit op_live = 1'b0;
  int op_cyc = 0, op_we = 0, op_addr = 0, op_wdata = 0;
  bit pend_fetch = 1'b0;
  int pend_k = 0, pend_addr = 0;
  int tv_count = 0, tick_count = 0;

  function automatic int dec_col(int h, int v);
    if (v < VBP || v >= VFP || h < HBP - 3) return -1;
    if ((h - (HBP - 3)) % 16 != 0) return -1;
    if ((h - (HBP - 3)) / 16 >= COLS) return -1;
    return (h - (HBP - 3)) / 16;
  endfunction

  function automatic bit is_active(int h, int v);
    return h >= HBP && h < HFP && v >= VBP && v < VFP;
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (hc=%0d vc=%0d)", name, act, exp, hc, vc);
    end
  endtask

  task automatic model_eval();
    int h, v, k, e_en, e_we, e_addr, e_wdata, e_ack, e_rdata, e_code;
    bit busy, can_take;
    h = int'(hc);
    v = int'(vc);
    if (!rst_n) begin
      op_live = 1'b0;
      pend_fetch = 1'b0;
      return;
    end
    cyc++;
    busy = op_live && (cyc <= op_cyc + 2);
    e_en = 0; e_we = 0; e_addr = 0; e_wdata = 0; e_ack = 0; e_rdata = 0;
    if (pend_fetch) begin
      e_en = 1;
      e_addr = pend_addr;
      fetch_val[pend_k] = ref_mem[pend_addr];
    end
    if (op_live && cyc == op_cyc + 1 && op_addr < NCELL) begin
      e_en = 1; e_we = op_we; e_addr = op_addr; e_wdata = op_wdata;
      if (op_we != 0) ref_mem[op_addr] = 4'(op_wdata);
    end
    if (op_live && cyc == op_cyc + 2) begin
      e_ack = 1;
      e_rdata = (op_we == 0 && op_addr < NCELL) ? int'(ref_mem[op_addr]) : 0;
    end
    e_code = is_active(h, v) ? int'(fetch_val[(h - HBP) / 16]) : 0;

    check("ram_en", int'(ram_en), e_en);
    if (e_en != 0) begin
      check("ram_we", int'(ram_we), e_we);
      check("ram_addr", int'(ram_addr), e_addr);
      if (e_we != 0) check("ram_wdata", int'(ram_wdata), e_wdata);
    end
    check("g_ack", int'(g_ack), e_ack);
    if (e_ack != 0 && op_we == 0) check("g_rdata", int'(g_rdata), e_rdata);
    check("tile_valid", int'(tile_valid), int'(is_active(h, v)));
    check("tile_code", int'(tile_code), e_code);
    check("frame_tick", int'(frame_tick), int'(h == 0 && v == VFP));
    tv_count += int'(tile_valid);
    tick_count += int'(frame_tick);

    k = dec_col(h, v);
    can_take = g_req && !busy && (k < 0);
`ifdef BLANK_WRITE_ONLY_EN
    if (g_we && v >= VBP && v < VFP) can_take = 1'b0;
`endif
    if (can_take) begin
      op_live = 1'b1; op_cyc = cyc; op_we = int'(g_we);
      op_addr = int'(g_addr); op_wdata = int'(g_wdata);
    end
    pend_fetch = (k >= 0);
    pend_k = (k >= 0) ? k : 0;
    pend_addr = ((v - VBP) / 16) * COLS + pend_k;
  endtask

  // Compare at the falling edge, then drive the next cycle just after the rising edge
  task automatic step();
    @(negedge dclk);
    model_eval();
    @(posedge dclk);
    #1;
    if (rst_n) begin
      if (hc == 10'd799) begin
        hc = 10'd0;
        vc = (vc == 10'd520) ? 10'd0 : vc + 10'd1;
      end else begin
        hc = hc + 10'd1;
      end
    end
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_g_ack"}, int'(g_ack), 0);
    check({tag, "_g_rdata"}, int'(g_rdata), 0);
    check({tag, "_ram_en"}, int'(ram_en), 0);
    check({tag, "_ram_we"}, int'(ram_we), 0);
    check({tag, "_ram_addr"}, int'(ram_addr), 0);
    check({tag, "_ram_wdata"}, int'(ram_wdata), 0);
    check({tag, "_tile_code"}, int'(tile_code), 0);
    check({tag, "_tile_valid"}, int'(tile_valid), 0);
    check({tag, "_frame_tick"}, int'(frame_tick), 0);
  endtask

  bit ack_prev;
  int wait_cnt;

  initial begin
    for (int i = 0; i < 2048; i++) ref_mem[i] = init_val(i);
    for (int i = 0; i < COLS; i++) fetch_val[i] = '0;

    // Reset state
    hc = 10'd0; vc = 10'd63;
    step(); step();
    check_all_zero("reset");
    rst_n = 1'b1;

    // Display fetch of cell 85 plus a game write landing on a decision cycle
    while (hc != 10'd221) step();
`ifndef BLANK_WRITE_ONLY_EN
    g_req = 1'b1; g_we = 1'b1; g_addr = 11'd85; g_wdata = 4'h3;
`endif
    step();
    check("fetch_en", int'(ram_en), 1);
    check("fetch_we", int'(ram_we), 0);
    check("fetch_addr", int'(ram_addr), 85);
    step();
`ifndef BLANK_WRITE_ONLY_EN
    check("gwr_en", int'(ram_en), 1);
    check("gwr_we", int'(ram_we), 1);
    check("gwr_addr", int'(ram_addr), 85);
    check("gwr_wdata", int'(ram_wdata), 3);
`endif
    step();
`ifndef BLANK_WRITE_ONLY_EN
    check("gwr_ack", int'(g_ack), 1);
`endif
    check("code_224", int'(tile_code), 9);
    check("valid_224", int'(tile_valid), 1);
    step();
    g_req = 1'b0; g_we = 1'b0;
    while (hc != 10'd239) step();
    check("code_239", int'(tile_code), 9);
    while (!(vc == 10'd64 && hc == 10'd230)) step();
`ifndef BLANK_WRITE_ONLY_EN
    check("code_after_wr", int'(tile_code), 3);
`else
    check("code_after_wr", int'(tile_code), 9);
`endif

    // Game reads: last valid cell, then first out-of-range address
    while (hc != 10'd790) step();
    g_req = 1'b1; g_we = 1'b0; g_addr = 11'd1199;
    step();
    check("rd_en", int'(ram_en), 1);
    check("rd_addr", int'(ram_addr), 1199);
    step();
    check("rd_ack", int'(g_ack), 1);
    check("rd_data", int'(g_rdata), 10);
    step();
    g_addr = 11'd1200;
    check("rd_ack_low", int'(g_ack), 0);
    step();
    check("oob_en", int'(ram_en), 0);
    step();
    check("oob_ack", int'(g_ack), 1);
    check("oob_data", int'(g_rdata), 0);
    step();
    g_req = 1'b0;

    // Reset asserted while a write is in ISSUE
    g_req = 1'b1; g_we = 1'b1; g_addr = 11'd100; g_wdata = init_val(100) ^ 4'hF;
    step();
    check("issue_en", int'(ram_en), 1);
    check("issue_we", int'(ram_we), 1);
    rst_n = 1'b0;
    g_req = 1'b0; g_we = 1'b0;
    #1;
    check_all_zero("midreset");
    step(); step();
    check("ram_unchanged", int'(mem[100]), int'(init_val(100)));
    hc = 10'd0; vc = 10'd40;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("no_late_ack", int'(g_ack), 0);
    end

    // Random game traffic over rows being displayed
    wait_cnt = 0;
    for (int n = 0; n < 4000; n++) begin
      ack_prev = g_ack;
      step();
      if (g_req) begin
        if (ack_prev) begin
          g_req = 1'b0;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
          if (wait_cnt > 40) begin
            checks++; errors++;
            $display("FAIL req_timeout: no g_ack after %0d cycles (hc=%0d vc=%0d)", wait_cnt, hc, vc);
            g_req = 1'b0;
            wait_cnt = 0;
          end
        end
      end
      if (!g_req && $urandom_range(0, 2) == 0) begin
        g_req = 1'b1;
`ifdef BLANK_WRITE_ONLY_EN
        g_we = 1'b0;
`else
        g_we = 1'($urandom_range(0, 1));
`endif
        case ($urandom_range(0, 5))
          0:       g_addr = 11'(1200 + $urandom_range(0, 40));
          1, 2:    g_addr = 11'($urandom_range(0, 39));
          default: g_addr = 11'($urandom_range(0, 1199));
        endcase
        g_wdata = 4'($urandom_range(0, 15));
        wait_cnt = 0;
      end
    end
    while (g_req) begin
      ack_prev = g_ack;
      step();
      if (ack_prev) g_req = 1'b0;
      else begin
        wait_cnt++;
        if (wait_cnt > 40) begin
          checks++; errors++;
          $display("FAIL drain_timeout: no g_ack (hc=%0d vc=%0d)", hc, vc);
          g_req = 1'b0;
        end
      end
    end
    step(); step();

    // End of frame: last two active lines and the vblank tick
    rst_n = 1'b0;
    step();
    hc = 10'd0; vc = 10'd509;
    rst_n = 1'b1;
    tv_count = 0;
    tick_count = 0;
    while (!(hc == 10'd0 && vc == 10'd512)) begin
      step();
      if (vc == 10'd510 && hc == 10'd783) check("last_active", int'(tile_valid), 1);
      if (vc == 10'd510 && hc == 10'd784) check("after_last", int'(tile_valid), 0);
      if (vc == 10'd511 && hc == 10'd0) check("tick_pos", int'(frame_tick), 1);
    end
    check("tick_count", tick_count, 1);
    check("valid_count", tv_count, 2 * 640);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
